performance_monitor_mc: RTL and testbench

//  Parametrised successor of the AXIS throughput monitor: NUM_STREAMS AXI-Stream sinks, each

---
 rtl/performance_monitor_mc.sv | 193 +++++++++++++++++++
 tb/tb_performance_monitor_mc.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/performance_monitor_mc.sv
// Multi-channel AXI-Stream beat counter: per-channel accepted beats over a fixed window, snapshotted at window end.
// Optional feature macro: PERF_MON_PEAK_EN adds a per-channel peak-snapshot register readable via command[4].
module performance_monitor_mc #(
  parameter logic [31:0] COUNT_CYCLES = 32'h000F_4240,
  parameter int          NUM_STREAMS  = 4,
  parameter int          DATA_WIDTH   = 128,
  parameter int          CNT_WIDTH    = 32
) (
  input  logic                              aclk,
  input  logic                              resetn,
  input  logic [NUM_STREAMS-1:0]            s_axis_tvalid,
  input  logic [NUM_STREAMS*DATA_WIDTH-1:0] s_axis_tdata,
  output logic [NUM_STREAMS-1:0]            s_axis_tready,
  input  logic [31:0]                       command,
  output logic [31:0]                       counter_value,
  output logic                              ready_to_read,
  output logic [1:0]                        dbg_state
);

  // Handshake: a beat on channel i is accepted in any cycle where s_axis_tvalid[i] and
  // s_axis_tready[i] are both high; tready is held high in every state once out of reset.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_CONT  = 2'b10;
  localparam logic [1:0] OP_ABORT = 2'b11;

  state_t                 state, state_nx;
  logic [31:0]            command_q;
  logic [31:0]            window_cnt;
  logic                   cont_q, cont_nx;
  logic                   rtr_nx;
  logic [CNT_WIDTH-1:0]   beat_cnt [NUM_STREAMS];
  logic [CNT_WIDTH-1:0]   beat_inc [NUM_STREAMS];
  logic [CNT_WIDTH-1:0]   snapshot [NUM_STREAMS];
  logic [NUM_STREAMS-1:0] beat;
  logic [1:0]             op;
  logic                   op_edge, start_hit, abort_hit, window_end;
  logic                   load_window, clear_cnt, take_snap, clear_peak;
  logic [31:0]            rd_val;
  logic                   unused_bits;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v, input logic b);
    return (b && (v != '1)) ? v + CNT_WIDTH'(1) : v;
  endfunction

  assign beat      = s_axis_tvalid & s_axis_tready;
  assign op        = command[31:30];
  assign op_edge   = (op != command_q[31:30]);
  assign start_hit = op_edge && ((op == OP_START) || (op == OP_CONT));
  assign abort_hit = op_edge && (op == OP_ABORT);
  assign window_end = (state == S_COUNT) && (window_cnt == 32'd0);
  assign dbg_state = state;
  assign unused_bits = ^{s_axis_tdata, command[29:4], command_q[29:0]};

  always_comb begin
    for (int i = 0; i < NUM_STREAMS; i++) begin
      beat_inc[i] = sat_inc(beat_cnt[i], beat[i]);
    end
  end

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Window-end bookkeeping is resolved first so that a same-cycle opcode overrides it.
  always_comb begin
    state_nx    = state;
    rtr_nx      = ready_to_read;
    cont_nx     = cont_q;
    load_window = 1'b0;
    clear_cnt   = 1'b0;
    take_snap   = 1'b0;
    clear_peak  = 1'b0;
    case (state)
      S_COUNT: begin
        if (window_end) begin
          take_snap = 1'b1;
          rtr_nx    = 1'b1;
          if (cont_q) begin
            load_window = 1'b1;
          end else begin
            state_nx = S_DONE;
          end
        end
      end
      default: begin
      end
    endcase
    if (abort_hit) begin
      state_nx    = S_IDLE;
      rtr_nx      = 1'b0;
      clear_cnt   = 1'b1;
      load_window = 1'b0;
    end else if (start_hit) begin
      state_nx    = S_COUNT;
      rtr_nx      = 1'b0;
      load_window = 1'b1;
      cont_nx     = (op == OP_CONT);
      clear_peak  = 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      s_axis_tready <= '0;
      command_q     <= '0;
      window_cnt    <= '0;
      cont_q        <= 1'b0;
      ready_to_read <= 1'b0;
    end else begin
      s_axis_tready <= '1;
      command_q     <= command;
      cont_q        <= cont_nx;
      ready_to_read <= rtr_nx;
      if (load_window) begin
        window_cnt <= COUNT_CYCLES - 32'd1;
      end else if ((state == S_COUNT) && (window_cnt != 32'd0)) begin
        window_cnt <= window_cnt - 32'd1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    for (int i = 0; i < NUM_STREAMS; i++) begin
      if (!resetn) begin
        beat_cnt[i] <= '0;
        snapshot[i] <= '0;
      end else begin
        if (load_window || clear_cnt) begin
          beat_cnt[i] <= '0;
        end else if (state == S_COUNT) begin
          beat_cnt[i] <= beat_inc[i];
        end
        if (take_snap) begin
          snapshot[i] <= beat_inc[i];
        end
      end
    end
  end

`ifdef PERF_MON_PEAK_EN
  logic [CNT_WIDTH-1:0] peak [NUM_STREAMS];

  // Peak tracks the largest snapshot since the last START/CONT; a START landing on a
  // window end clears it after that final snapshot.
  always_ff @(posedge aclk) begin
    for (int i = 0; i < NUM_STREAMS; i++) begin
      if (!resetn || clear_peak) begin
        peak[i] <= '0;
      end else if (take_snap && (beat_inc[i] > peak[i])) begin
        peak[i] <= beat_inc[i];
      end
    end
  end

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_STREAMS; i++) begin
      if (command[3:0] == 4'(i)) begin
        rd_val = command[4] ? 32'(peak[i]) : 32'(snapshot[i]);
      end
    end
  end
`else
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_STREAMS; i++) begin
      if (command[3:0] == 4'(i)) begin
        rd_val = 32'(snapshot[i]);
      end
    end
  end
`endif

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      counter_value <= '0;
    end else begin
      counter_value <= rd_val;
    end
  end

endmodule

// File: tb/tb_performance_monitor_mc.sv
// Directed bench for performance_monitor_mc: a 16-cycle window instance plus a 3-bit saturating twin.
module tb_performance_monitor_mc;
  localparam int NS = 4;
  localparam int DW = 128;
  localparam logic [1:0] NOP = 2'b00, START = 2'b01, CONT = 2'b10, ABORT = 2'b11;

  typedef struct {
    logic [4:0]  sel;
    logic [31:0] exp_val;
    logic [31:0] exp_sat;
  } vec_t;

  logic             aclk = 1'b0;
  logic             resetn;
  logic [NS-1:0]    tvalid;
  logic [NS*DW-1:0] tdata;
  logic [NS-1:0]    tready, tready_sat;
  logic [31:0]      command;
  logic [31:0]      cv, cv_sat;
  logic             rtr, rtr_sat;
  logic [1:0]       st, st_sat;
  logic             toggle2;
  int               errors = 0;
  int               checks = 0;
  logic [31:0]      exp_q[$];
  vec_t             vecs[7];

  always #5 aclk = ~aclk;

  performance_monitor_mc #(.COUNT_CYCLES(32'd16), .NUM_STREAMS(NS), .DATA_WIDTH(DW), .CNT_WIDTH(32)) dut (
    .aclk(aclk), .resetn(resetn), .s_axis_tvalid(tvalid), .s_axis_tdata(tdata),
    .s_axis_tready(tready), .command(command), .counter_value(cv),
    .ready_to_read(rtr), .dbg_state(st)
  );

  performance_monitor_mc #(.COUNT_CYCLES(32'd16), .NUM_STREAMS(NS), .DATA_WIDTH(DW), .CNT_WIDTH(3)) dut_sat (
    .aclk(aclk), .resetn(resetn), .s_axis_tvalid(tvalid), .s_axis_tdata(tdata),
    .s_axis_tready(tready_sat), .command(command), .counter_value(cv_sat),
    .ready_to_read(rtr_sat), .dbg_state(st_sat)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge aclk);
      #1;
      if (toggle2) tvalid[2] = ~tvalid[2];
      tdata = {16{$urandom()}};
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic check_sb(input string name, input logic [31:0] act);
    logic [31:0] expv;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got %0d", name, act);
    end else begin
      expv = exp_q.pop_front();
      check(name, act, expv);
    end
  endtask

  task automatic issue(input logic [1:0] op);
    command[31:30] = op;
    tick(1);
  endtask

  initial begin
    vecs[0] = '{5'h00, 32'd16, 32'd7};
    vecs[1] = '{5'h01, 32'd0,  32'd0};
    vecs[2] = '{5'h02, 32'd0,  32'd0};
    vecs[3] = '{5'h03, 32'd0,  32'd0};
    vecs[4] = '{5'h08, 32'd0,  32'd0};
    vecs[5] = '{5'h0F, 32'd0,  32'd0};
    vecs[6] = '{5'h10, 32'd16, 32'd7};

    resetn  = 1'b0;
    command = '0;
    tvalid  = '0;
    tdata   = '0;
    toggle2 = 1'b0;
    tick(2);
    check("reset_tready", 32'(tready), 32'd0);
    check("reset_cv", cv, 32'd0);
    check("reset_rtr", 32'(rtr), 32'd0);
    check("reset_state", 32'(st), 32'd0);
    resetn = 1'b1;
    tick(1);
    check("tready_after_reset", 32'(tready), 32'hF);

    // Single-shot window, ch0 always valid
    tvalid = 4'b0001;
    issue(START);
    check("t1_state_count", 32'(st), 32'd1);
    tick(15);
    check("t1_rtr_before_end", 32'(rtr), 32'd0);
    tick(1);
    check("t1_rtr_at_end", 32'(rtr), 32'd1);
    check("t1_state_done", 32'(st), 32'd2);
    for (int i = 0; i < 7; i++) begin
      command[4:0] = vecs[i].sel;
      exp_q.push_back(vecs[i].exp_val);
      exp_q.push_back(vecs[i].exp_sat);
      tick(1);
      check_sb($sformatf("t1_sel%0d", vecs[i].sel), cv);
      check_sb($sformatf("t1_sat_sel%0d", vecs[i].sel), cv_sat);
    end

    // Saturation on ch1 with 3-bit counters
    issue(NOP);
    tvalid = 4'b0010;
    command[4:0] = 5'h01;
    issue(START);
    check("t4_rtr_dropped", 32'(rtr), 32'd0);
    tick(16);
    check("t4_rtr", 32'(rtr), 32'd1);
    tick(1);
    check("t4_sat_ch1", cv_sat, 32'd7);
    check("t4_full_ch1", cv, 32'd16);

    // Continuous windows, ch2 alternating then constant
    issue(NOP);
    tvalid = 4'b0000;
    command[4:0] = 5'h02;
    toggle2 = 1'b1;
    issue(CONT);
    tick(15);
    check("t2_rtr_before_end", 32'(rtr), 32'd0);
    tick(1);
    check("t2_rtr_end", 32'(rtr), 32'd1);
    check("t2_state_count", 32'(st), 32'd1);
    tick(1);
    check("t2_win1", cv, 32'd8);
    for (int i = 0; i < 15; i++) begin
      tick(1);
      check("t2_rtr_held", 32'(rtr), 32'd1);
    end
    toggle2 = 1'b0;
    tvalid[2] = 1'b1;
    tick(16);
    check("t2_win2", cv, 32'd8);
    tick(1);
    check("t2_win3_full", cv, 32'd16);
    check("t2_rtr_still", 32'(rtr), 32'd1);

    // Abort mid-window keeps previous snapshot
    issue(ABORT);
    check("t3_abort_idle", 32'(st), 32'd0);
    check("t3_abort_rtr", 32'(rtr), 32'd0);
    issue(START);
    check("t3_restart", 32'(st), 32'd1);
    tick(4);
    issue(ABORT);
    check("t3_idle", 32'(st), 32'd0);
    check("t3_rtr", 32'(rtr), 32'd0);
    tick(1);
    check("t3_snapshot_kept", cv, 32'd16);

    // Reset pulse mid-window
    issue(START);
    tick(5);
    resetn  = 1'b0;
    command = '0;
    tick(1);
    check("t5_tready", 32'(tready), 32'd0);
    check("t5_cv", cv, 32'd0);
    check("t5_rtr", 32'(rtr), 32'd0);
    check("t5_state", 32'(st), 32'd0);
    resetn = 1'b1;
    command[4:0] = 5'h02;
    tick(1);
    check("t5_tready_back", 32'(tready), 32'hF);
    tick(1);
    check("t5_cv_cleared", cv, 32'd0);
    check("t5_state_idle", 32'(st), 32'd0);

`ifdef PERF_MON_PEAK_EN
    begin
      int loads [3];
      loads = '{4, 12, 6};
      tvalid = '0;
      command[4:0] = 5'h03;
      issue(CONT);
      for (int w = 0; w < 3; w++) begin
        for (int c = 0; c < 16; c++) begin
          tvalid[3] = (c < loads[w]);
          tick(1);
        end
      end
      tvalid = '0;
      command[4:0] = 5'h13;
      tick(1);
      check("t6_peak", cv, 32'd12);
      command[4:0] = 5'h03;
      tick(1);
      check("t6_last", cv, 32'd6);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
